// File: rtl/shift_pkg.sv
// Shared constants and state encoding for the iterative shifter.
package shift_pkg;

  localparam int unsigned SH_WIDTH    = 32;
  localparam int unsigned SH_AMT_W    = 5;
  localparam int unsigned SH_BIG_STEP = 4;

  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_SHIFT = 2'd1,
    SH_FIN   = 2'd2
  } sh_state_e;

endpackage

// File: rtl/shl_iter_if.sv
// Request/result bundle between the execute stage and the iterative shifter.
interface shl_iter_if;
  import shift_pkg::*;

  logic                Start;
  logic                Rot;
  logic [SH_WIDTH-1:0] ShIn;
  logic [SH_AMT_W-1:0] Shamt;
  logic                Busy;
  logic                Done;
  logic [SH_WIDTH-1:0] ShOut;

  modport master (
    output Start, Rot, ShIn, Shamt,
    input  Busy, Done, ShOut
  );

  modport slave (
    input  Start, Rot, ShIn, Shamt,
    output Busy, Done, ShOut
  );
endinterface

// File: rtl/shl_step.sv
// One shift step: moves the operand left by 4 or 1, optionally rotating the
// bits shifted out of the top back into the bottom.
module shl_step
  import shift_pkg::*;
(
  input  logic [SH_WIDTH-1:0] Acc,
  input  logic                big,
  input  logic                rot,
  output logic [SH_WIDTH-1:0] NextAcc
);

  always_comb begin
    NextAcc = Acc;
    if (big) begin
      NextAcc = {Acc[SH_WIDTH-SH_BIG_STEP-1:0],
                 Acc[SH_WIDTH-1 -: SH_BIG_STEP] & {SH_BIG_STEP{rot}}};
    end else begin
      NextAcc = {Acc[SH_WIDTH-2:0], Acc[SH_WIDTH-1] & rot};
    end
  end

endmodule

// File: rtl/shl_iter.sv
// Iterative 32-bit shift-left / rotate-left unit; up to 4 positions per cycle.
// Busy and Done decode from the state register only.
module shl_iter
  import shift_pkg::*;
(
  input  logic      CLK,
  input  logic      RESET,
  shl_iter_if.slave bus
);

  sh_state_e           state_q;
  logic [SH_WIDTH-1:0] acc_q;
  logic [SH_WIDTH-1:0] acc_d;
  logic [SH_WIDTH-1:0] sh_out_q;
  logic [SH_AMT_W-1:0] rem_q;
  logic [SH_AMT_W-1:0] rem_d;
  logic                rot_q;
  logic                big;

  // A 4-step only when at least 4 remain, so rem never wraps.
  assign big   = (rem_q >= SH_AMT_W'(SH_BIG_STEP));
  assign rem_d = big ? (rem_q - SH_AMT_W'(SH_BIG_STEP)) : (rem_q - SH_AMT_W'(1));

  shl_step u_step (
    .Acc     (acc_q),
    .big     (big),
    .rot     (rot_q),
    .NextAcc (acc_d)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= SH_IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      rot_q    <= 1'b0;
      sh_out_q <= '0;
    end else begin
      case (state_q)
        SH_IDLE: begin
          if (bus.Start) begin
            acc_q <= bus.ShIn;
            rem_q <= bus.Shamt;
            rot_q <= bus.Rot;
            if (bus.Shamt != '0) begin
              state_q <= SH_SHIFT;
            end else begin
              sh_out_q <= bus.ShIn;
              state_q  <= SH_FIN;
            end
          end
        end
        SH_SHIFT: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          // Result is captured on the edge entering FIN.
          if (rem_d == '0) begin
            sh_out_q <= acc_d;
            state_q  <= SH_FIN;
          end
        end
        SH_FIN:  state_q <= SH_IDLE;
        default: state_q <= SH_IDLE;
      endcase
    end
  end

  assign bus.Busy  = (state_q != SH_IDLE);
  assign bus.Done  = (state_q == SH_FIN);
  assign bus.ShOut = sh_out_q;

endmodule

// File: tb/tb_shl_iter.sv
// Directed and sweep checks for the iterative shifter: results, latency,
// ignored requests while busy, and reset abandoning an operation.
module tb_shl_iter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  shl_iter_if bus ();

  shl_iter dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input int s, input logic r);
    logic [31:0] lo;
    lo = x << s;
    if (r && s != 0) lo = lo | (x >> (32 - s));
    return lo;
  endfunction

  // Drives a request in the current cycle k and returns in cycle k+1.
  task automatic start_op(input logic [31:0] x, input logic [4:0] s, input logic r);
    bus.Start = 1'b1;
    bus.ShIn  = x;
    bus.Shamt = s;
    bus.Rot   = r;
    tick();
    bus.Start = 1'b0;
  endtask

  // Called in cycle k+c0; returns in the Done cycle (or on timeout).
  task automatic wait_done(input string tag, input int c0, input int exp_n,
                           input logic [31:0] exp_out);
    int   c;
    logic busy_ok;
    c       = c0;
    busy_ok = 1'b1;
    while (bus.Done !== 1'b1 && c < 16) begin
      if (bus.Busy !== 1'b1) busy_ok = 1'b0;
      tick();
      c++;
    end
    chk({tag, " latency"}, 32'(c), 32'(exp_n + 1));
    chk({tag, " busy"}, {31'd0, busy_ok & bus.Busy}, 32'd1);
    chk({tag, " shout"}, bus.ShOut, exp_out);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " idle busy"}, {31'd0, bus.Busy}, 32'd0);
    chk({tag, " idle done"}, {31'd0, bus.Done}, 32'd0);
  endtask

  initial begin
    logic [31:0] x;
    logic        saw_done;

    rst       = 1'b1;
    bus.Start = 1'b0;
    bus.Rot   = 1'b0;
    bus.ShIn  = '0;
    bus.Shamt = '0;
    tick();
    tick();
    chk("reset busy", {31'd0, bus.Busy}, 32'd0);
    chk("reset done", {31'd0, bus.Done}, 32'd0);
    chk("reset shout", bus.ShOut, 32'd0);
    rst = 1'b0;
    tick();

    start_op(32'h0000_0001, 5'd31, 1'b0);
    wait_done("sll31", 1, 10, 32'h8000_0000);
    tick();
    check_idle("sll31");

    start_op(32'h8000_0001, 5'd4, 1'b1);
    wait_done("rol4", 1, 1, 32'h0000_0018);
    tick();

    // 8 set bits rotated left by 7 land in bits 10..3.
    start_op(32'hF000_000F, 5'd7, 1'b1);
    wait_done("rol7", 1, 4, 32'h0000_07F8);
    tick();

    start_op(32'hDEAD_BEEF, 5'd0, 1'b0);
    wait_done("zero", 1, 0, 32'hDEAD_BEEF);
    tick();
    check_idle("zero");

    // Request in cycle k+2 of a long operation must be dropped.
    start_op(32'h0000_0001, 5'd31, 1'b0);
    tick();
    bus.Start = 1'b1;
    bus.ShIn  = 32'h1234_5678;
    bus.Shamt = 5'd3;
    bus.Rot   = 1'b0;
    tick();
    bus.Start = 1'b0;
    wait_done("ign busy", 3, 10, 32'h8000_0000);
    // Request held from the Done cycle into the following IDLE cycle.
    bus.Start = 1'b1;
    tick();
    check_idle("ign done");
    tick();
    bus.Start = 1'b0;
    wait_done("b2b", 1, 3, 32'h91A2_B3C0);
    tick();

    // Reset in cycle k+3 of a 20-position shift.
    start_op(32'hFFFF_FFFF, 5'd20, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", {31'd0, bus.Busy}, 32'd0);
    chk("midrst shout", bus.ShOut, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.Done === 1'b1) saw_done = 1'b1;
      tick();
    end
    chk("midrst no done", {31'd0, saw_done}, 32'd0);

    for (int s = 0; s < 32; s++) begin
      for (int r = 0; r < 2; r++) begin
        x = $urandom;
        start_op(x, 5'(s), 1'(r));
        wait_done($sformatf("sweep s=%0d r=%0d", s, r), 1, (s >> 2) + (s & 3),
                  ref_shift(x, s, 1'(r)));
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
